// File: rtl/riscv_m_pkg.sv
// Shared RISC-V M-extension encodings and sequencer states, imported by the
// decode, issue and multiply/divide logic.
package riscv_m_pkg;

    typedef enum logic [2:0] {
        OpMul    = 3'b000,
        OpMulh   = 3'b001,
        OpMulhsu = 3'b010,
        OpMulhu  = 3'b011,
        OpDiv    = 3'b100,
        OpDivu   = 3'b101,
        OpRem    = 3'b110,
        OpRemu   = 3'b111
    } m_op_e;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StCalc = 2'b01,
        StDone = 2'b10
    } m_state_e;

    function automatic logic op_is_div(m_op_e op);
        return op inside {OpDiv, OpDivu, OpRem, OpRemu};
    endfunction

    function automatic logic op_is_rem(m_op_e op);
        return op inside {OpRem, OpRemu};
    endfunction

    function automatic logic rs1_signed(m_op_e op);
        return op inside {OpMul, OpMulh, OpMulhsu, OpDiv, OpRem};
    endfunction

    function automatic logic rs2_signed(m_op_e op);
        return op inside {OpMul, OpMulh, OpDiv, OpRem};
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Issue/result handshake bundle between the issue stage and the mul/div unit.
interface muldiv_unit_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [XLEN-1:0]  in_rs1;
    logic [XLEN-1:0]  in_rs2;
    logic [TAG_W-1:0] in_tag;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_result;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    modport master (
        output in_valid, in_op, in_rs1, in_rs2, in_tag, flush, out_ready,
        input  in_ready, out_valid, out_result, out_tag, busy
    );

    modport slave (
        input  in_valid, in_op, in_rs1, in_rs2, in_tag, flush, out_ready,
        output in_ready, out_valid, out_result, out_tag, busy
    );
endinterface

// File: rtl/muldiv_iter.sv
// One radix-2 step: shift-add multiply on {hi, lo}, or restoring divide with
// hi as partial remainder and lo shifting dividend out / quotient in.
module muldiv_iter #(
    parameter int unsigned XLEN = 32
) (
    input  logic            is_div_i,
    input  logic [XLEN-1:0] hi_i,
    input  logic [XLEN-1:0] lo_i,
    input  logic [XLEN-1:0] opnd_i,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o
);
    logic [XLEN:0] sum;
    logic [XLEN:0] rem_sh;
    logic [XLEN:0] diff;

    always_comb begin
        sum    = {1'b0, hi_i} + (lo_i[0] ? {1'b0, opnd_i} : '0);
        rem_sh = {hi_i, lo_i[XLEN-1]};
        diff   = rem_sh - {1'b0, opnd_i};
        if (is_div_i) begin
            // hi stays below the divisor, so diff's top bit is a clean borrow flag
            if (diff[XLEN]) begin
                hi_o = rem_sh[XLEN-1:0];
                lo_o = {lo_i[XLEN-2:0], 1'b0};
            end else begin
                hi_o = diff[XLEN-1:0];
                lo_o = {lo_i[XLEN-2:0], 1'b1};
            end
        end else begin
            hi_o = sum[XLEN:1];
            lo_o = {sum[0], lo_i[XLEN-1:1]};
        end
    end
endmodule

// File: rtl/muldiv_unit.sv
// Iterative RISC-V M multiply/divide unit: magnitude datapath with sign fix-up,
// divide fast paths, valid/ready result hold and flush.
module muldiv_unit
    import riscv_m_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
) (
    input logic          clk,
    input logic          rst,
    muldiv_unit_if.slave bus
);
    localparam int unsigned CntW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

    m_state_e         state_q, state_d;
    m_op_e            op_q, op_d;
    logic             sign_res_q, sign_res_d;
    logic             sign_rem_q, sign_rem_d;
    logic [XLEN-1:0]  opnd_q, opnd_d;
    logic [XLEN-1:0]  hi_q, hi_d;
    logic [XLEN-1:0]  lo_q, lo_d;
    logic [XLEN-1:0]  result_q, result_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    m_op_e             op_in;
    logic              s1, s2, accept, div_zero, div_ovf, iter_is_div;
    logic [XLEN-1:0]   mag1, mag2, fast_res, hi_n, lo_n, quot_s, rem_s, final_res;
    logic [2*XLEN-1:0] prod_s;

    assign op_in       = m_op_e'(bus.in_op);
    assign iter_is_div = op_is_div(op_q);

    muldiv_iter #(
        .XLEN(XLEN)
    ) u_iter (
        .is_div_i(iter_is_div),
        .hi_i    (hi_q),
        .lo_i    (lo_q),
        .opnd_i  (opnd_q),
        .hi_o    (hi_n),
        .lo_o    (lo_n)
    );

    always_comb begin
        accept   = bus.in_valid && (state_q == StIdle) && !bus.flush;
        s1       = rs1_signed(op_in) && bus.in_rs1[XLEN-1];
        s2       = rs2_signed(op_in) && bus.in_rs2[XLEN-1];
        mag1     = s1 ? -bus.in_rs1 : bus.in_rs1;
        mag2     = s2 ? -bus.in_rs2 : bus.in_rs2;
        div_zero = op_is_div(op_in) && (bus.in_rs2 == '0);
        div_ovf  = (op_in inside {OpDiv, OpRem}) && (bus.in_rs1 == MinNeg) && (&bus.in_rs2);
        if (div_zero) fast_res = op_is_rem(op_in) ? bus.in_rs1 : '1;
        else          fast_res = op_is_rem(op_in) ? '0 : bus.in_rs1;

        // Sign fix-up uses the final iteration's outputs so DONE is entered directly
        prod_s = sign_res_q ? -{hi_n, lo_n} : {hi_n, lo_n};
        quot_s = sign_res_q ? -lo_n : lo_n;
        rem_s  = sign_rem_q ? -hi_n : hi_n;
        case (op_q)
            OpMul:                     final_res = prod_s[XLEN-1:0];
            OpMulh, OpMulhsu, OpMulhu: final_res = prod_s[2*XLEN-1:XLEN];
            OpRem, OpRemu:             final_res = rem_s;
            default:                   final_res = quot_s;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        sign_res_d = sign_res_q;
        sign_rem_d = sign_rem_q;
        opnd_d     = opnd_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        result_d   = result_q;
        tag_d      = tag_q;
        out_tag_d  = out_tag_q;
        cnt_d      = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    // Multiply is commutative, so both ops load rs1 into lo and rs2 as operand
                    op_d       = op_in;
                    sign_res_d = s1 ^ s2;
                    sign_rem_d = s1;
                    opnd_d     = mag2;
                    hi_d       = '0;
                    lo_d       = mag1;
                    tag_d      = bus.in_tag;
                    cnt_d      = '0;
                    if (div_zero || div_ovf) begin
                        state_d   = StDone;
                        result_d  = fast_res;
                        out_tag_d = bus.in_tag;
                    end else begin
                        state_d = StCalc;
                    end
                end
            end
            StCalc: begin
                hi_d  = hi_n;
                lo_d  = lo_n;
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntW'(XLEN - 1)) begin
                    state_d   = StDone;
                    result_d  = final_res;
                    out_tag_d = tag_q;
                    cnt_d     = '0;
                end
            end
            StDone: begin
                if (bus.out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (bus.flush) begin
            state_d   = StIdle;
            result_d  = result_q;
            out_tag_d = out_tag_q;
            cnt_d     = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StIdle;
            op_q       <= OpMul;
            sign_res_q <= 1'b0;
            sign_rem_q <= 1'b0;
            opnd_q     <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            result_q   <= '0;
            tag_q      <= '0;
            out_tag_q  <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            sign_res_q <= sign_res_d;
            sign_rem_q <= sign_rem_d;
            opnd_q     <= opnd_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            result_q   <= result_d;
            tag_q      <= tag_d;
            out_tag_q  <= out_tag_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.in_ready   = (state_q == StIdle);
    assign bus.busy       = (state_q != StIdle);
    assign bus.out_valid  = (state_q == StDone);
    assign bus.out_result = result_q;
    assign bus.out_tag    = out_tag_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit at XLEN=32: arithmetic, latency, fast paths,
// backpressure, flush and mid-operation reset.
module tb_muldiv_unit;
    localparam int NormLat = 33;  // first valid cycle after accept edge, counting that cycle as 1
    localparam int FastLat = 1;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   lat;
    logic seen;

    muldiv_unit_if #(.XLEN(32), .TAG_W(5)) bus ();

    muldiv_unit #(
        .XLEN (32),
        .TAG_W(5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge right after the accept edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_rs1   = a;
        bus.in_rs2   = b;
        bus.in_tag   = tag;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int cycles);
        cycles = 1;
        while (!bus.out_valid && cycles < 200) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] tag, input logic [31:0] exp,
                          input int exp_lat);
        int l;
        check({name, " in_ready"}, 64'(bus.in_ready), 64'd1);
        issue(op, a, b, tag);
        check({name, " busy"}, 64'(bus.busy), 64'd1);
        wait_valid(l);
        check({name, " latency"}, 64'(l), 64'(exp_lat));
        check({name, " result"}, 64'(bus.out_result), 64'(exp));
        check({name, " tag"}, 64'(bus.out_tag), 64'(tag));
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({name, " idle after ready"}, 64'(bus.in_ready), 64'd1);
        check({name, " valid dropped"}, 64'(bus.out_valid), 64'd0);
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_op     = 3'b000;
        bus.in_rs1    = '0;
        bus.in_rs2    = '0;
        bus.in_tag    = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset out_valid", 64'(bus.out_valid), 64'd0);
        check("reset in_ready", 64'(bus.in_ready), 64'd1);
        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset out_result", 64'(bus.out_result), 64'd0);
        check("reset out_tag", 64'(bus.out_tag), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        run_op("MUL 7*-3",     3'b000, 32'd7,        32'hFFFFFFFD, 5'd3,  32'hFFFFFFEB, NormLat);
        run_op("MULH min*min", 3'b001, 32'h80000000, 32'h80000000, 5'd4,  32'h40000000, NormLat);
        run_op("MULHU",        3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5,  32'hFFFFFFFE, NormLat);
        run_op("MULHSU",       3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  32'hFFFFFFFF, NormLat);
        run_op("DIV -7/2",     3'b100, 32'hFFFFFFF9, 32'd2,        5'd7,  32'hFFFFFFFD, NormLat);
        run_op("REM -7/2",     3'b110, 32'hFFFFFFF9, 32'd2,        5'd8,  32'hFFFFFFFF, NormLat);
        run_op("REMU",         3'b111, 32'hFFFFFFF9, 32'd2,        5'd9,  32'd1,        NormLat);
        run_op("DIVU 5/0",     3'b101, 32'd5,        32'd0,        5'd10, 32'hFFFFFFFF, FastLat);
        run_op("REM 5/0",      3'b110, 32'd5,        32'd0,        5'd11, 32'd5,        FastLat);
        run_op("DIV ovf",      3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'h80000000, FastLat);
        run_op("REM ovf",      3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'd0,        FastLat);

        // Backpressure: result held for 10 cycles while a new op is offered
        issue(3'b100, 32'd100, 32'd7, 5'd17);
        wait_valid(lat);
        check("bp latency", 64'(lat), 64'(NormLat));
        bus.in_valid = 1'b1;
        bus.in_op    = 3'b000;
        for (int i = 0; i < 10; i++) begin
            check("bp valid held", 64'(bus.out_valid), 64'd1);
            check("bp result held", 64'(bus.out_result), 64'd14);
            check("bp tag held", 64'(bus.out_tag), 64'd17);
            check("bp in_ready low", 64'(bus.in_ready), 64'd0);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("bp idle after ready", 64'(bus.in_ready), 64'd1);
        check("bp no accept on release", 64'(bus.busy), 64'd0);
        bus.in_valid = 1'b0;
        @(negedge clk);

        // Flush in CALC cycle 12
        issue(3'b000, 32'h12345678, 32'd9, 5'd19);
        lat = 1;
        while (lat < 12) begin
            @(negedge clk);
            lat++;
        end
        check("flush still calc", 64'(bus.busy), 64'd1);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush in_ready", 64'(bus.in_ready), 64'd1);
        check("flush busy", 64'(bus.busy), 64'd0);
        check("flush out_valid", 64'(bus.out_valid), 64'd0);
        check("flush result untouched", 64'(bus.out_result), 64'd14);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        check("flush no late valid", 64'(seen), 64'd0);
        run_op("MUL 3*4", 3'b000, 32'd3, 32'd4, 5'd20, 32'd12, NormLat);

        // Reset in CALC cycle 20
        issue(3'b101, 32'd1000, 32'd3, 5'd21);
        lat = 1;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
        end
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("rst mid in_ready", 64'(bus.in_ready), 64'd1);
        check("rst mid busy", 64'(bus.busy), 64'd0);
        check("rst mid out_valid", 64'(bus.out_valid), 64'd0);
        check("rst mid out_result", 64'(bus.out_result), 64'd0);
        check("rst mid out_tag", 64'(bus.out_tag), 64'd0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        check("rst no late valid", 64'(seen), 64'd0);
        run_op("DIVU after rst", 3'b101, 32'd1000, 32'd3, 5'd22, 32'd333, NormLat);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
